// File: rtl/pwm_output_stage.sv
// 16-pin PWM output stage: a shared prescaled 8-bit counter drives per-pin off/high/PWM outputs.
// The duty cycle is shadowed and reloaded only at the period wrap so a write never glitches a pin.
module pwm_output_stage #(
  parameter int unsigned PRESCALE = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0_i,
  input  logic [7:0]  en_reg_out_15_8_i,
  input  logic [7:0]  en_reg_pwm_7_0_i,
  input  logic [7:0]  en_reg_pwm_15_8_i,
  input  logic [7:0]  pwm_duty_cycle_i,
  output logic [15:0] pwm_out_o,
  output logic        period_start_o
);

  localparam logic [7:0] PsMax  = 8'(PRESCALE - 1);
  localparam logic [7:0] CntMax = 8'hFF;

  logic [7:0]  prescaler_q, prescaler_d;
  logic [7:0]  counter_q, counter_d;
  logic [7:0]  duty_shadow_q, duty_shadow_d;
  logic [15:0] pwm_out_q, pwm_out_d;
  logic        wrap_q;
  logic        period_start_q;

  logic        tick;
  logic        wrap;
  logic        pwm_sig;
  logic [15:0] en_out;
  logic [15:0] en_pwm;

  assign en_out = {en_reg_out_15_8_i, en_reg_out_7_0_i};
  assign en_pwm = {en_reg_pwm_15_8_i, en_reg_pwm_7_0_i};

  assign tick = (prescaler_q == PsMax);
  assign wrap = tick && (counter_q == CntMax);

  always_comb begin
    prescaler_d   = tick ? 8'd0 : prescaler_q + 8'd1;
    counter_d     = tick ? counter_q + 8'd1 : counter_q;
    duty_shadow_d = wrap ? pwm_duty_cycle_i : duty_shadow_q;
  end

  // 0xFF is forced fully on; otherwise a plain compare would leave a one-step dip at count 255.
  always_comb begin
    pwm_sig   = (duty_shadow_q == 8'hFF) || (counter_q < duty_shadow_q);
    pwm_out_d = en_out & (~en_pwm | {16{pwm_sig}});
  end

  // wrap_q delays the pulse one more clock so it lines up with pwm_out showing count 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler_q    <= 8'd0;
      counter_q      <= 8'd0;
      duty_shadow_q  <= 8'd0;
      pwm_out_q      <= 16'd0;
      wrap_q         <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      prescaler_q    <= prescaler_d;
      counter_q      <= counter_d;
      duty_shadow_q  <= duty_shadow_d;
      pwm_out_q      <= pwm_out_d;
      wrap_q         <= wrap;
      period_start_q <= wrap_q;
    end
  end

  assign pwm_out_o      = pwm_out_q;
  assign period_start_o = period_start_q;

endmodule

// File: tb/tb_pwm_output_stage.sv
// Self-checking bench for pwm_output_stage: directed test-plan scenarios plus randomized enables
// and duty, all compared every clock against an arithmetic model of period/duty timing.
module tb_pwm_output_stage;

  localparam int P   = 13;
  localparam int PER = 256 * P;

  logic        clk;
  logic        rst_n;
  logic [15:0] en_out;
  logic [15:0] en_pwm;
  logic [7:0]  duty;
  logic [15:0] pwm_out;
  logic        period_start;

  int n_vec;
  int n_err;

  // Model state: clocks elapsed since reset release and the duty of the running period.
  int          e;
  logic [7:0]  m_duty;
  logic [15:0] exp_pwm;
  logic        exp_ps;

  pwm_output_stage #(
    .PRESCALE(P)
  ) u_dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .en_reg_out_7_0_i  (en_out[7:0]),
    .en_reg_out_15_8_i (en_out[15:8]),
    .en_reg_pwm_7_0_i  (en_pwm[7:0]),
    .en_reg_pwm_15_8_i (en_pwm[15:8]),
    .pwm_duty_cycle_i  (duty),
    .pwm_out_o         (pwm_out),
    .period_start_o    (period_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  // One clock: predict the registered outputs from the inputs held at this edge, then compare.
  task automatic step();
    int  cnt;
    bit  sig;
    @(posedge clk);
    if (!rst_n) begin
      e       = 0;
      m_duty  = 8'h00;
      exp_pwm = 16'h0000;
      exp_ps  = 1'b0;
    end else begin
      cnt = (e / P) % 256;
      sig = (m_duty == 8'hFF) || (cnt < int'(m_duty));
      for (int i = 0; i < 16; i++)
        exp_pwm[i] = en_out[i] && (en_pwm[i] ? sig : 1'b1);
      exp_ps = (e > 0) && (e % PER == 0);
      if (e % PER == PER - 1) m_duty = duty;
      e++;
    end
    #1;
    check_eq("pwm_out", 32'(pwm_out), 32'(exp_pwm));
    check_eq("period_start", 32'(period_start), 32'(exp_ps));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Advance to the sample where period_start is high, bounded by a little over one period.
  task automatic sync_period();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!period_start && n < PER + 16);
    check_eq("sync_timeout", 32'(period_start), 32'd1);
  endtask

  task automatic high_time(input int b, output int hi);
    hi = 0;
    for (int i = 0; i < PER; i++) begin
      if (pwm_out[b]) hi++;
      step();
    end
  endtask

  initial begin
    int hi;
    n_vec  = 0;
    n_err  = 0;
    e      = 0;
    m_duty = 8'h00;
    en_out = 16'hFFFF;
    en_pwm = 16'h0000;
    duty   = 8'h00;
    rst_n  = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check_eq("reset_pwm_out", 32'(pwm_out), 32'h0);
    check_eq("reset_period_start", 32'(period_start), 32'h0);
    run(3);

    // Static-high pins after release, through the first wrap.
    @(negedge clk) rst_n = 1'b1;
    step();
    check_eq("static_high", 32'(pwm_out), 32'hFFFF);
    run(PER + 20);

    // 50% on bit 0; rising edge coincides with period_start.
    en_out = 16'h0001;
    en_pwm = 16'h0001;
    duty   = 8'h80;
    sync_period();
    check_eq("b0_rise_at_ps", 32'(pwm_out), 32'h0001);
    high_time(0, hi);
    check_eq("b0_high_time", 32'(hi), 32'd1664);

    // Duty boundaries on bit 15.
    en_out = 16'h8000;
    en_pwm = 16'h8000;
    duty   = 8'h00;
    sync_period();
    high_time(15, hi);
    check_eq("b15_duty00", 32'(hi), 32'd0);
    duty = 8'hFF;
    sync_period();
    high_time(15, hi);
    check_eq("b15_duty_ff", 32'(hi), 32'(PER));
    high_time(15, hi);
    check_eq("b15_duty_ff_wrap", 32'(hi), 32'(PER));
    duty = 8'h01;
    sync_period();
    high_time(15, hi);
    check_eq("b15_duty01", 32'(hi), 32'd13);

    // Mid-period duty write is held off until the next period.
    duty = 8'h40;
    sync_period();
    hi = 0;
    for (int i = 0; i < PER; i++) begin
      if (pwm_out[15]) hi++;
      if (i == 1000) duty = 8'hC0;
      step();
    end
    check_eq("glitch_old_high", 32'(hi), 32'd832);
    check_eq("glitch_new_ps", 32'(period_start), 32'd1);
    high_time(15, hi);
    check_eq("glitch_new_high", 32'(hi), 32'd2496);

    // Enable precedence, then PWM-mode disable mid low phase.
    en_out = 16'h00FF;
    en_pwm = 16'hFFFF;
    duty   = 8'h80;
    sync_period();
    sync_period();
    run(100);
    check_eq("prec_high", 32'(pwm_out), 32'h00FF);
    run(2000);
    check_eq("prec_low", 32'(pwm_out), 32'h0000);
    en_pwm = 16'h0000;
    step();
    check_eq("pwm_off_1clk", 32'(pwm_out), 32'h00FF);

    // Randomized enables and duty across several periods.
    for (int i = 0; i < 4 * PER; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        en_out = 16'($urandom);
        en_pwm = 16'($urandom);
      end
      if ($urandom_range(0, 999) == 0) duty = 8'($urandom);
      step();
    end

    // Asynchronous reset in the high phase.
    en_out = 16'h00FF;
    en_pwm = 16'h00FF;
    duty   = 8'h80;
    sync_period();
    sync_period();
    run(50);
    check_eq("pre_reset_high", 32'(pwm_out), 32'h00FF);
    #3 rst_n = 1'b0;
    #1;
    check_eq("async_reset_pwm", 32'(pwm_out), 32'h0);
    check_eq("async_reset_ps", 32'(period_start), 32'h0);
    run(3);
    @(negedge clk) rst_n = 1'b1;
    run(200);
    check_eq("post_reset_duty0", 32'(pwm_out), 32'h0);
    run(PER + 20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
